// File: rtl/fetch_align_buffer.sv
// Halfword fetch queue: re-aligns 16/32-bit instructions across word boundaries.
// Optional compressed-instruction support is enabled by defining FETCH_BUFFER_COMPRESSED_EN.
module fetch_align_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic [31:0] rdata_i,
  input  logic        error_i,
  input  logic        ready_i,
  input  logic        clear_i,
  input  logic        stall_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic        miss_o,
  output logic        done_o,
  output logic        stall_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   hw_q  [DEPTH];
  logic [31:0]   pc_q  [DEPTH];
  logic          err_q [DEPTH];
  logic [PW-1:0] rptr, wptr, rptr1, wptr1;
  logic [CW-1:0] count, push_n, pop_n, need, free;
  logic          push_req, push_ok, hi_only, is32, avail, load_en;
  logic [15:0]   h0, h1;
  logic [31:0]   base_pc, instr_next;
  logic          miss_next;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^pc_i[1:0];

`ifdef FETCH_BUFFER_COMPRESSED_EN
  assign hi_only = pc_i[1];
`else
  assign hi_only = 1'b0;
`endif

  assign base_pc  = {pc_i[31:2], 2'b00};
  assign push_n   = hi_only ? CW'(1) : CW'(2);
  assign free     = CW'(DEPTH) - count;
  assign push_req = ready_i & ~clear_i;
  assign push_ok  = push_req && (free >= push_n);
  assign wptr1    = wptr + PW'(1);
  assign rptr1    = rptr + PW'(1);

  assign h0 = hw_q[rptr];
  assign h1 = hw_q[rptr1];

`ifdef FETCH_BUFFER_COMPRESSED_EN
  assign is32       = (h0[1:0] == 2'b11);
  assign instr_next = is32 ? {h1, h0} : {16'h0000, h0};
`else
  assign is32       = 1'b1;
  assign instr_next = {h1, h0};
`endif

  assign need      = is32 ? CW'(2) : CW'(1);
  assign avail     = (count >= need);
  assign miss_next = err_q[rptr] | (is32 & err_q[rptr1]);
  assign load_en   = ~done_o | ~stall_i;
  assign pop_n     = (load_en && avail && !clear_i) ? need : CW'(0);
  assign stall_o   = (count > CW'(DEPTH - 4));

  // Storage carries no reset: entries are only visible through count.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) begin
      if (hi_only) begin
        hw_q[wptr]  <= rdata_i[31:16];
        pc_q[wptr]  <= pc_i;
        err_q[wptr] <= error_i;
      end else begin
        hw_q[wptr]   <= rdata_i[15:0];
        pc_q[wptr]   <= base_pc;
        err_q[wptr]  <= error_i;
        hw_q[wptr1]  <= rdata_i[31:16];
        pc_q[wptr1]  <= base_pc + 32'd2;
        err_q[wptr1] <= error_i;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      pc_o    <= '0;
      instr_o <= '0;
      miss_o  <= 1'b0;
      done_o  <= 1'b0;
    end else if (clear_i) begin
      rptr   <= '0;
      wptr   <= '0;
      count  <= '0;
      miss_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PW'(push_n);
      count <= count + (push_ok ? push_n : CW'(0)) - pop_n;
      if (load_en) begin
        if (avail) begin
          pc_o    <= pc_q[rptr];
          instr_o <= instr_next;
          miss_o  <= miss_next;
          done_o  <= 1'b1;
          rptr    <= rptr + PW'(need);
        end else begin
          done_o <= 1'b0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(push_req && !push_ok));
`endif

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed self-checking bench for fetch_align_buffer; compressed tests run when
// FETCH_BUFFER_COMPRESSED_EN is defined.
module tb_fetch_align_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_i = '0, rdata_i = '0;
  logic        error_i = 1'b0, ready_i = 1'b0, clear_i = 1'b0, stall_i = 1'b0;
  logic [31:0] pc_o, instr_o;
  logic        miss_o, done_o, stall_o;
  int          checks = 0;
  int          errors = 0;

  fetch_align_buffer #(.DEPTH(8)) dut (
    .clock(clock), .reset(reset), .pc_i(pc_i), .rdata_i(rdata_i),
    .error_i(error_i), .ready_i(ready_i), .clear_i(clear_i), .stall_i(stall_i),
    .pc_o(pc_o), .instr_o(instr_o), .miss_o(miss_o), .done_o(done_o),
    .stall_o(stall_o)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    ready_i = 0; clear_i = 0; stall_i = 0; error_i = 0;
    reset = 1;
    cyc(); cyc();
    reset = 0;
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] data, input logic err);
    pc_i = pc; rdata_i = data; error_i = err; ready_i = 1;
    cyc();
    ready_i = 0; error_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", pc_o); end
    checks++; if (instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr_o); end
    checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b want 0", miss_o); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_o); end
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall_o); end
    // reset in the middle of a push leaves nothing behind
    pc_i = 32'h80; rdata_i = 32'h00A00093; ready_i = 1; reset = 1;
    cyc();
    ready_i = 0; reset = 0;
    cyc(); cyc();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_midop_done: got %b want 0", done_o); end
  endtask

  task automatic test_basic32();
    do_reset();
    push_word(32'h100, 32'h00A00093, 1'b0);
    cyc();
    checks++; if (done_o !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done_o); end
    checks++; if (pc_o !== 32'h100) begin errors++; $display("FAIL basic_pc: got %h want 100", pc_o); end
    checks++; if (instr_o !== 32'h00A00093) begin errors++; $display("FAIL basic_instr: got %h want 00a00093", instr_o); end
    checks++; if (miss_o !== 1'b0) begin errors++; $display("FAIL basic_miss: got %b want 0", miss_o); end
    cyc();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL basic_drain_done: got %b want 0", done_o); end
  endtask

`ifdef FETCH_BUFFER_COMPRESSED_EN
  task automatic test_compressed_pair();
    do_reset();
    push_word(32'h200, 32'h45014505, 1'b0);
    cyc();
    checks++; if (pc_o !== 32'h200 || instr_o !== 32'h00004505 || done_o !== 1'b1) begin
      errors++; $display("FAIL c16_first: got pc=%h instr=%h done=%b want 200/00004505/1", pc_o, instr_o, done_o); end
    cyc();
    checks++; if (pc_o !== 32'h202 || instr_o !== 32'h00004501 || done_o !== 1'b1) begin
      errors++; $display("FAIL c16_second: got pc=%h instr=%h done=%b want 202/00004501/1", pc_o, instr_o, done_o); end
  endtask

  task automatic test_straddle();
    do_reset();
    push_word(32'h200, 32'h00934505, 1'b0);
    cyc();
    checks++; if (pc_o !== 32'h200 || instr_o !== 32'h00004505 || done_o !== 1'b1) begin
      errors++; $display("FAIL straddle_c16: got pc=%h instr=%h done=%b want 200/00004505/1", pc_o, instr_o, done_o); end
    cyc();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL straddle_early: got done=%b want 0", done_o); end
    push_word(32'h204, 32'h123400A0, 1'b0);
    cyc();
    checks++; if (pc_o !== 32'h202 || instr_o !== 32'h00A00093 || done_o !== 1'b1) begin
      errors++; $display("FAIL straddle_i32: got pc=%h instr=%h done=%b want 202/00a00093/1", pc_o, instr_o, done_o); end
    cyc();
    checks++; if (pc_o !== 32'h206 || instr_o !== 32'h00001234 || done_o !== 1'b1) begin
      errors++; $display("FAIL straddle_tail: got pc=%h instr=%h done=%b want 206/00001234/1", pc_o, instr_o, done_o); end
  endtask
`endif

  task automatic test_fault();
    do_reset();
    push_word(32'h300, 32'h00A00093, 1'b1);
    cyc();
    checks++; if (done_o !== 1'b1 || miss_o !== 1'b1 || pc_o !== 32'h300) begin
      errors++; $display("FAIL fault: got done=%b miss=%b pc=%h want 1/1/300", done_o, miss_o, pc_o); end
    push_word(32'h304, 32'h00B00113, 1'b0);
    cyc();
    checks++; if (done_o !== 1'b1 || miss_o !== 1'b0 || pc_o !== 32'h304) begin
      errors++; $display("FAIL fault_clean: got done=%b miss=%b pc=%h want 1/0/304", done_o, miss_o, pc_o); end
  endtask

  task automatic test_backpressure();
    do_reset();
    stall_i = 1;
    push_word(32'h500, 32'h00A00093, 1'b0);
    cyc();
    checks++; if (done_o !== 1'b1 || pc_o !== 32'h500) begin
      errors++; $display("FAIL bp_first: got done=%b pc=%h want 1/500", done_o, pc_o); end
    push_word(32'h504, 32'h00B00113, 1'b0);
    push_word(32'h508, 32'h00C00193, 1'b0);
    checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL bp_stall_at4: got %b want 0", stall_o); end
    push_word(32'h50C, 32'h00D00213, 1'b0);
    checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL bp_stall_at6: got %b want 1", stall_o); end
    checks++; if (pc_o !== 32'h500 || instr_o !== 32'h00A00093 || done_o !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got pc=%h instr=%h done=%b want 500/00a00093/1", pc_o, instr_o, done_o); end
    stall_i = 0;
    cyc();
    checks++; if (pc_o !== 32'h504 || instr_o !== 32'h00B00113 || stall_o !== 1'b0) begin
      errors++; $display("FAIL bp_drain1: got pc=%h instr=%h stall=%b want 504/00b00113/0", pc_o, instr_o, stall_o); end
    cyc();
    checks++; if (pc_o !== 32'h508 || instr_o !== 32'h00C00193) begin
      errors++; $display("FAIL bp_drain2: got pc=%h instr=%h want 508/00c00193", pc_o, instr_o); end
    cyc();
    checks++; if (pc_o !== 32'h50C || instr_o !== 32'h00D00213 || done_o !== 1'b1) begin
      errors++; $display("FAIL bp_drain3: got pc=%h instr=%h done=%b want 50c/00d00213/1", pc_o, instr_o, done_o); end
    cyc();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got done=%b want 0", done_o); end
  endtask

  task automatic test_clear();
    do_reset();
    stall_i = 1;
    push_word(32'h600, 32'h00A00093, 1'b0);
    cyc();
    push_word(32'h604, 32'h00B00113, 1'b0);
    push_word(32'h60A, 32'h00C00193, 1'b0);
    pc_i = 32'h700; rdata_i = 32'h00D00213; ready_i = 1; clear_i = 1;
    cyc();
    ready_i = 0; clear_i = 0; stall_i = 0;
    checks++; if (done_o !== 1'b0 || miss_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL clear: got done=%b miss=%b stall=%b want 0/0/0", done_o, miss_o, stall_o); end
    cyc();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL clear_empty: got done=%b want 0", done_o); end
`ifdef FETCH_BUFFER_COMPRESSED_EN
    push_word(32'h402, 32'h45050000, 1'b0);
    cyc();
    checks++; if (pc_o !== 32'h402 || instr_o !== 32'h00004505 || done_o !== 1'b1) begin
      errors++; $display("FAIL clear_hi_only: got pc=%h instr=%h done=%b want 402/00004505/1", pc_o, instr_o, done_o); end
`else
    push_word(32'h400, 32'h00A00093, 1'b0);
    cyc();
    checks++; if (pc_o !== 32'h400 || instr_o !== 32'h00A00093 || done_o !== 1'b1) begin
      errors++; $display("FAIL clear_refill: got pc=%h instr=%h done=%b want 400/00a00093/1", pc_o, instr_o, done_o); end
`endif
    cyc();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL clear_refill_drain: got done=%b want 0", done_o); end
  endtask

  initial begin
    test_reset();
    test_basic32();
`ifdef FETCH_BUFFER_COMPRESSED_EN
    test_compressed_pair();
    test_straddle();
`endif
    test_fault();
    test_backpressure();
    test_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
